alu_operand_collector: RTL and testbench

- Upstream front-end stage for the N-bit ALU; collects operands that arrive in different cycles.
- Host-side operand A and operand B may arrive split across cycles, flagged by inp_valid.
- Block decodes which operands each mode/cmd needs, waits a bounded number of cycles for missing ones, then issues one complete, registered command to the ALU with inp_valid=2'b11 and ce pulsed for exactly one cycle.
- Flags illegal commands and operand timeouts.

---
 rtl/alu_operand_collector_if.sv | 47 ++++
 rtl/alu_operand_collector.sv | 199 +++++++++++++++++++
 tb/tb_alu_operand_collector.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_collector_if.sv
// Bundle of host-side operand signals and ALU-side issue signals for the
// operand collector. Optional macro ALU_COLLECT_STATS_EN adds the
// issue_cnt/tout_cnt statistics outputs.
interface alu_operand_collector_if #(
  parameter int N = 8
);
  logic         ce;
  logic [1:0]   inp_valid;
  logic         mode;
  logic [3:0]   cmd;
  logic         cin;
  logic [N-1:0] opa;
  logic [N-1:0] opb;

  logic         ready;
  logic         alu_ce;
  logic [1:0]   alu_inp_valid;
  logic         alu_mode;
  logic [3:0]   alu_cmd;
  logic         alu_cin;
  logic [N-1:0] alu_opa;
  logic [N-1:0] alu_opb;
  logic         cmd_err;
  logic         tout_err;
`ifdef ALU_COLLECT_STATS_EN
  logic [15:0]  issue_cnt;
  logic [15:0]  tout_cnt;
`endif

  modport master (
    output ce, inp_valid, mode, cmd, cin, opa, opb,
    input  ready, alu_ce, alu_inp_valid, alu_mode, alu_cmd, alu_cin,
    input  alu_opa, alu_opb, cmd_err, tout_err
`ifdef ALU_COLLECT_STATS_EN
    , input issue_cnt, tout_cnt
`endif
  );

  modport slave (
    input  ce, inp_valid, mode, cmd, cin, opa, opb,
    output ready, alu_ce, alu_inp_valid, alu_mode, alu_cmd, alu_cin,
    output alu_opa, alu_opb, cmd_err, tout_err
`ifdef ALU_COLLECT_STATS_EN
    , output issue_cnt, tout_cnt
`endif
  );
endinterface

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: gathers operand A/B that may arrive in different
// cycles, waits up to TIMEOUT enabled cycles for missing ones, then issues one
// registered command to the ALU with a single-cycle alu_ce pulse. Illegal
// commands pulse cmd_err, wait expiry pulses tout_err.
// Optional macro ALU_COLLECT_STATS_EN adds saturating issue/timeout counters.
module alu_operand_collector #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_operand_collector_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ISSUE
  } state_t;

  state_t       state;
  state_t       next_state;

  logic [CW-1:0] wait_cnt;
  logic          hold_mode;
  logic [3:0]    hold_cmd;
  logic          hold_cin;
  logic [N-1:0]  hold_opa;
  logic [N-1:0]  hold_opb;
  logic          have_a;
  logic          have_b;

  logic [2:0]    in_need;
  logic [2:0]    hold_need;
  logic          in_complete;
  logic          wait_complete;
  logic          accept;
  logic          illegal_now;
  logic          tout_now;
  logic          issue_now;

  // Need encoding: bit2 = illegal, bit1 = needs B, bit0 = needs A.
  function automatic logic [2:0] decode_need(input logic m, input logic [3:0] c);
    logic [2:0] need;
    need = 3'b011;
    if (m) begin
      case (c)
        4'd4, 4'd5:           need = 3'b001;
        4'd6, 4'd7:           need = 3'b010;
        4'd13, 4'd14, 4'd15:  need = 3'b100;
        default:              need = 3'b011;
      endcase
    end else begin
      case (c)
        4'd6, 4'd8, 4'd9:     need = 3'b001;
        4'd7, 4'd10, 4'd11:   need = 3'b010;
        4'd14, 4'd15:         need = 3'b100;
        default:              need = 3'b011;
      endcase
    end
    return need;
  endfunction

  assign in_need       = decode_need(bus.mode, bus.cmd);
  assign hold_need     = decode_need(hold_mode, hold_cmd);
  assign in_complete   = (!in_need[0] || bus.inp_valid[0]) &&
                         (!in_need[1] || bus.inp_valid[1]);
  assign wait_complete = (!hold_need[0] || have_a || bus.inp_valid[0]) &&
                         (!hold_need[1] || have_b || bus.inp_valid[1]);
  assign bus.ready     = (state == IDLE);

  // State register; everything freezes while ce is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the single-cycle event strobes.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    illegal_now = 1'b0;
    tout_now    = 1'b0;
    issue_now   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ce && (bus.inp_valid != 2'b00)) begin
          accept = 1'b1;
          if (in_need[2]) begin
            illegal_now = 1'b1;
          end else if (in_complete) begin
            next_state = ISSUE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.ce) begin
          if (wait_complete) begin
            next_state = ISSUE;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            tout_now   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      ISSUE: begin
        if (bus.ce) begin
          issue_now  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Holding registers, wait counter and the registered ALU-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt          <= '0;
      hold_mode         <= 1'b0;
      hold_cmd          <= 4'd0;
      hold_cin          <= 1'b0;
      hold_opa          <= '0;
      hold_opb          <= '0;
      have_a            <= 1'b0;
      have_b            <= 1'b0;
      bus.alu_ce        <= 1'b0;
      bus.alu_inp_valid <= 2'b00;
      bus.alu_mode      <= 1'b0;
      bus.alu_cmd       <= 4'd0;
      bus.alu_cin       <= 1'b0;
      bus.alu_opa       <= '0;
      bus.alu_opb       <= '0;
      bus.cmd_err       <= 1'b0;
      bus.tout_err      <= 1'b0;
    end else begin
      bus.alu_ce        <= 1'b0;
      bus.alu_inp_valid <= 2'b00;
      bus.cmd_err       <= illegal_now;
      bus.tout_err      <= tout_now;
      if (accept) begin
        hold_mode <= bus.mode;
        hold_cmd  <= bus.cmd;
        hold_cin  <= bus.cin;
        have_a    <= bus.inp_valid[0];
        have_b    <= bus.inp_valid[1];
        if (bus.inp_valid[0]) hold_opa <= bus.opa;
        if (bus.inp_valid[1]) hold_opb <= bus.opb;
        wait_cnt  <= CW'(1);
      end else if (tout_now) begin
        have_a   <= 1'b0;
        have_b   <= 1'b0;
        wait_cnt <= '0;
      end else if ((state == WAIT) && bus.ce) begin
        if (!have_a && bus.inp_valid[0]) begin
          hold_opa <= bus.opa;
          have_a   <= 1'b1;
        end
        if (!have_b && bus.inp_valid[1]) begin
          hold_opb <= bus.opb;
          have_b   <= 1'b1;
        end
        if (next_state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      end else if (issue_now) begin
        bus.alu_ce        <= 1'b1;
        bus.alu_inp_valid <= 2'b11;
        bus.alu_mode      <= hold_mode;
        bus.alu_cmd       <= hold_cmd;
        bus.alu_cin       <= hold_cin;
        bus.alu_opa       <= hold_need[0] ? hold_opa : '0;
        bus.alu_opb       <= hold_need[1] ? hold_opb : '0;
        have_a            <= 1'b0;
        have_b            <= 1'b0;
        wait_cnt          <= '0;
      end
    end
  end

`ifdef ALU_COLLECT_STATS_EN
  // Saturating counts of issued commands and wait timeouts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.issue_cnt <= 16'd0;
      bus.tout_cnt  <= 16'd0;
    end else begin
      if (issue_now && (bus.issue_cnt != 16'hFFFF)) bus.issue_cnt <= bus.issue_cnt + 16'd1;
      if (tout_now && (bus.tout_cnt != 16'hFFFF))   bus.tout_cnt  <= bus.tout_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// Self-checking bench for alu_operand_collector: directed scenarios followed by
// randomized traffic, all compared against a command-level reference model.
module tb_alu_operand_collector;

  localparam int N       = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  alu_operand_collector_if #(.N(N)) bus ();

  alu_operand_collector #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the pending command and what the outputs should be.
  bit        mCollect;
  bit        mIssue;
  int        mWaited;
  bit        mMode;
  bit [3:0]  mCmd;
  bit        mCin;
  bit        mGotA;
  bit        mGotB;
  bit [7:0]  mA;
  bit [7:0]  mB;

  bit        eAluCe;
  bit [1:0]  eIv;
  bit        eMode;
  bit [3:0]  eCmd;
  bit        eCin;
  bit [7:0]  eOpa;
  bit [7:0]  eOpb;
  bit        eCmdErr;
  bit        eTout;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Operand needs as a mask: 1 = A, 2 = B, 3 = both, 0 = illegal.
  function automatic int needOf(input bit m, input bit [3:0] c);
    if (m) begin
      if (c inside {4'd4, 4'd5}) return 1;
      if (c inside {4'd6, 4'd7}) return 2;
      if (c >= 4'd13) return 0;
      return 3;
    end
    if (c inside {4'd6, 4'd8, 4'd9}) return 1;
    if (c inside {4'd7, 4'd10, 4'd11}) return 2;
    if (c >= 4'd14) return 0;
    return 3;
  endfunction

  task automatic modelReset();
    mCollect = 0; mIssue = 0; mWaited = 0;
    mMode = 0; mCmd = 0; mCin = 0; mGotA = 0; mGotB = 0; mA = 0; mB = 0;
    eAluCe = 0; eIv = 0; eMode = 0; eCmd = 0; eCin = 0; eOpa = 0; eOpb = 0;
    eCmdErr = 0; eTout = 0;
  endtask

  task automatic modelStep(input bit ce, input bit [1:0] iv, input bit m, input bit [3:0] c,
                           input bit ci, input bit [7:0] a, input bit [7:0] b);
    int need;
    eAluCe  = 0;
    eIv     = 0;
    eCmdErr = 0;
    eTout   = 0;
    if (!ce) return;
    if (mIssue) begin
      need   = needOf(mMode, mCmd);
      eAluCe = 1;
      eIv    = 2'b11;
      eMode  = mMode;
      eCmd   = mCmd;
      eCin   = mCin;
      eOpa   = ((need & 1) != 0) ? mA : 8'h00;
      eOpb   = ((need & 2) != 0) ? mB : 8'h00;
      mIssue = 0;
    end else if (mCollect) begin
      need = needOf(mMode, mCmd);
      if (!mGotA && iv[0]) begin mA = a; mGotA = 1; end
      if (!mGotB && iv[1]) begin mB = b; mGotB = 1; end
      if (((need & 1) == 0 || mGotA) && ((need & 2) == 0 || mGotB)) begin
        mCollect = 0;
        mIssue   = 1;
      end else if (mWaited == TIMEOUT) begin
        eTout    = 1;
        mCollect = 0;
      end else begin
        mWaited++;
      end
    end else if (iv != 2'b00) begin
      need = needOf(m, c);
      if (need == 0) begin
        eCmdErr = 1;
      end else begin
        mMode = m; mCmd = c; mCin = ci;
        mGotA = iv[0]; mGotB = iv[1];
        mA = iv[0] ? a : 8'h00;
        mB = iv[1] ? b : 8'h00;
        if (((need & 1) == 0 || mGotA) && ((need & 2) == 0 || mGotB)) begin
          mIssue = 1;
        end else begin
          mCollect = 1;
          mWaited  = 1;
        end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".ready"},     bus.ready,         (mCollect || mIssue) ? 0 : 1);
    checkOutput({tag, ".alu_ce"},    bus.alu_ce,        eAluCe);
    checkOutput({tag, ".alu_iv"},    bus.alu_inp_valid, eIv);
    checkOutput({tag, ".alu_mode"},  bus.alu_mode,      eMode);
    checkOutput({tag, ".alu_cmd"},   bus.alu_cmd,       eCmd);
    checkOutput({tag, ".alu_cin"},   bus.alu_cin,       eCin);
    checkOutput({tag, ".alu_opa"},   bus.alu_opa,       eOpa);
    checkOutput({tag, ".alu_opb"},   bus.alu_opb,       eOpb);
    checkOutput({tag, ".cmd_err"},   bus.cmd_err,       eCmdErr);
    checkOutput({tag, ".tout_err"},  bus.tout_err,      eTout);
  endtask

  task automatic applyStimulus(input bit ce, input bit [1:0] iv, input bit m, input bit [3:0] c,
                               input bit ci, input bit [7:0] a, input bit [7:0] b, input string tag);
    bus.ce        = ce;
    bus.inp_valid = iv;
    bus.mode      = m;
    bus.cmd       = c;
    bus.cin       = ci;
    bus.opa       = a;
    bus.opb       = b;
    modelStep(ce, iv, m, c, ci, a, b);
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b1, 2'b00, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, tag);
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b0;
    #2;
    modelReset();
    checkAll(tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // Main sequence: reset, directed scenarios, randomized traffic, summary.
  initial begin
    rst           = 1'b1;
    bus.ce        = 1'b0;
    bus.inp_valid = 2'b00;
    bus.mode      = 1'b0;
    bus.cmd       = 4'd0;
    bus.cin       = 1'b0;
    bus.opa       = 8'h00;
    bus.opb       = 8'h00;
    modelReset();
    #1;
    applyReset("reset");
    checkOutput("reset_ready", bus.ready, 1);

    // Both operands together: issue one cycle after accept.
    applyStimulus(1'b1, 2'b11, 1'b1, 4'd0, 1'b0, 8'h12, 8'h34, "t1_accept");
    checkOutput("t1_ready_low", bus.ready, 0);
    idleCycle("t1_issue");
    checkOutput("t1_alu_ce", bus.alu_ce, 1);
    checkOutput("t1_alu_iv", bus.alu_inp_valid, 2'b11);
    checkOutput("t1_alu_opa", bus.alu_opa, 8'h12);
    checkOutput("t1_alu_opb", bus.alu_opb, 8'h34);
    idleCycle("t1_after");
    checkOutput("t1_ce_drop", bus.alu_ce, 0);
    checkOutput("t1_opa_hold", bus.alu_opa, 8'h12);

    // Split arrival with idle gap.
    applyStimulus(1'b1, 2'b01, 1'b1, 4'd0, 1'b0, 8'hAA, 8'h00, "t2_a");
    repeat (3) idleCycle("t2_gap");
    applyStimulus(1'b1, 2'b10, 1'b1, 4'd0, 1'b0, 8'h00, 8'h55, "t2_b");
    idleCycle("t2_issue");
    checkOutput("t2_alu_ce", bus.alu_ce, 1);
    checkOutput("t2_alu_opa", bus.alu_opa, 8'hAA);
    checkOutput("t2_alu_opb", bus.alu_opb, 8'h55);
    checkOutput("t2_tout", bus.tout_err, 0);

    // Timeout after TIMEOUT enabled waiting cycles.
    applyStimulus(1'b1, 2'b01, 1'b0, 4'd12, 1'b0, 8'h3C, 8'h00, "t3_a");
    repeat (TIMEOUT - 1) idleCycle("t3_wait");
    checkOutput("t3_no_early_tout", bus.tout_err, 0);
    idleCycle("t3_last");
    checkOutput("t3_tout", bus.tout_err, 1);
    checkOutput("t3_ready", bus.ready, 1);
    checkOutput("t3_no_issue", bus.alu_ce, 0);
    idleCycle("t3_after");
    checkOutput("t3_tout_drop", bus.tout_err, 0);

    // Illegal command.
    applyStimulus(1'b1, 2'b11, 1'b1, 4'd14, 1'b0, 8'h01, 8'h02, "t4");
    checkOutput("t4_cmd_err", bus.cmd_err, 1);
    checkOutput("t4_no_issue", bus.alu_ce, 0);
    checkOutput("t4_ready", bus.ready, 1);
    idleCycle("t4_after");
    checkOutput("t4_cmd_err_drop", bus.cmd_err, 0);

    // A-only command, unneeded B driven as zero.
    applyStimulus(1'b1, 2'b01, 1'b1, 4'd4, 1'b0, 8'hFF, 8'h77, "t5");
    idleCycle("t5_issue");
    checkOutput("t5_alu_ce", bus.alu_ce, 1);
    checkOutput("t5_alu_opa", bus.alu_opa, 8'hFF);
    checkOutput("t5_alu_opb", bus.alu_opb, 8'h00);

    // ce low freezes the wait.
    applyStimulus(1'b1, 2'b01, 1'b1, 4'd1, 1'b1, 8'h11, 8'h00, "t6_a");
    repeat (20) applyStimulus(1'b0, 2'b10, 1'b1, 4'd3, 1'b0, 8'h00, 8'h99, "t6_frozen");
    applyStimulus(1'b1, 2'b10, 1'b1, 4'd1, 1'b1, 8'h00, 8'h22, "t6_b");
    idleCycle("t6_issue");
    checkOutput("t6_alu_ce", bus.alu_ce, 1);
    checkOutput("t6_alu_opb", bus.alu_opb, 8'h22);
    checkOutput("t6_alu_cin", bus.alu_cin, 1);
    checkOutput("t6_tout", bus.tout_err, 0);

    // Asynchronous reset mid-wait.
    applyStimulus(1'b1, 2'b01, 1'b1, 4'd0, 1'b0, 8'h5A, 8'h00, "t7_a");
    idleCycle("t7_wait");
    applyReset("t7_rst");
    checkOutput("t7_ready", bus.ready, 1);
    checkOutput("t7_alu_opa", bus.alu_opa, 8'h00);
    idleCycle("t7_after");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit       rce;
      bit [1:0] riv;
      rce = mIssue ? 1'b1 : ($urandom_range(0, 9) != 0);
      riv = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      applyStimulus(rce, riv, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
